particle_frame_buffer: RTL and testbench

- Parametrised double-buffered frame store between the particle position pipeline and the TMDS encoders.
- Accepts plotted pixels through a valid/ready handshake into the back bank, while the front bank is read out, scaled, against the video timing counters.
- Swaps banks only at a frame boundary, then hardware-clears the new back bank. Clear colour, resolution and integer upscale are configurable.
- Outputs 8-bit R/G/B with fixed latency.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_bank.sv | 27 ++
 rtl/particle_frame_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_particle_frame_buffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the particle frame buffer.
package fb_pkg;

    typedef enum logic [1:0] {
        INIT,
        DRAW,
        CLEAR
    } fb_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Left-justified expansion: low bits are zero-filled, not replicated.
    function automatic logic [23:0] rgb565_to_rgb888(input rgb565_t c);
        return {c.r, 3'b000, c.g, 2'b00, c.b, 3'b000};
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM with a single write port and a registered read port.
module fb_bank #(
    parameter int DEPTH = 57600,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 16
) (
    input  logic          clk_pixel,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_pixel) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_pixel) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/particle_frame_buffer.sv
// Double-buffered RGB565 frame store: plots land in the back bank while the front bank
// is scanned out, optionally upscaled, against the video timing counters.
//
// state | meaning
// INIT  | fill both banks with CLEAR_COLOR after reset
// DRAW  | accept plots into the back bank; swap at frame end when one is pending
// CLEAR | fill the new back bank with CLEAR_COLOR after a swap
module particle_frame_buffer
    import fb_pkg::*;
#(
    parameter int          FB_WIDTH       = 320,
    parameter int          FB_HEIGHT      = 180,
    parameter int          H_TOTAL        = 1650,
    parameter int          V_TOTAL        = 750,
    parameter logic [15:0] CLEAR_COLOR    = 16'h0000,
    parameter int          MAX_SCALE_LOG2 = 2
) (
    input  logic        clk_pixel,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [1:0]  scale_log2_in,
    input  logic        plot_valid_in,
    output logic        plot_ready_out,
    input  logic [15:0] plot_x_in,
    input  logic [15:0] plot_y_in,
    input  logic [15:0] plot_color_in,
    input  logic        swap_req_in,
    output logic        swap_done_out,
    output logic        busy_out,
    output logic [15:0] drop_count_out,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out
);

    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int AW        = $clog2(FB_PIXELS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_PIXELS - 1);
    localparam logic [1:0]    MAX_SCALE = 2'(MAX_SCALE_LOG2);

    fb_state_t     state, state_d;
    logic [AW-1:0] clear_addr, clear_addr_d;
    logic          front_sel, front_sel_d;
    logic          swap_pend, swap_pend_d;
    logic          swap_done_d;
    logic [1:0]    scale_q, scale_d;
    logic [15:0]   drop_count_d;

    logic          frame_end;
    logic          plot_in_bounds;
    logic [AW-1:0] plot_addr;
    logic          we0, we1;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;

    logic [10:0]   hs;
    logic [9:0]    vs;
    logic          in_range_c;
    logic [AW-1:0] raddr_c;
    logic          in_range_s1, in_range_s2;
    logic          sel_s1, sel_s2;
    logic [AW-1:0] raddr_s1;
    logic [15:0]   rdata0, rdata1;
    rgb565_t       pix_s2;
    logic [23:0]   rgb888_s2;

    assign frame_end      = (hcount_in == 11'(H_TOTAL - 1)) && (vcount_in == 10'(V_TOTAL - 1));
    assign plot_in_bounds = (plot_x_in < 16'(FB_WIDTH)) && (plot_y_in < 16'(FB_HEIGHT));
    assign plot_addr      = AW'(plot_y_in) * AW'(FB_WIDTH) + AW'(plot_x_in);

    always_ff @(posedge clk_pixel or negedge rst_in) begin
        if (!rst_in) begin
            state          <= INIT;
            clear_addr     <= '0;
            front_sel      <= 1'b0;
            swap_pend      <= 1'b0;
            swap_done_out  <= 1'b0;
            scale_q        <= 2'd0;
            drop_count_out <= 16'd0;
        end else begin
            state          <= state_d;
            clear_addr     <= clear_addr_d;
            front_sel      <= front_sel_d;
            swap_pend      <= swap_pend_d;
            swap_done_out  <= swap_done_d;
            scale_q        <= scale_d;
            drop_count_out <= drop_count_d;
        end
    end

    always_comb begin
        state_d        = state;
        clear_addr_d   = clear_addr;
        front_sel_d    = front_sel;
        swap_pend_d    = swap_pend | swap_req_in;
        swap_done_d    = 1'b0;
        scale_d        = scale_q;
        drop_count_d   = drop_count_out;
        we0            = 1'b0;
        we1            = 1'b0;
        waddr          = plot_addr;
        wdata          = plot_color_in;
        plot_ready_out = (state == DRAW);
        busy_out       = (state != DRAW);

        if (frame_end) begin
            scale_d = (scale_log2_in > MAX_SCALE) ? MAX_SCALE : scale_log2_in;
        end

        // Bank 0 is front when front_sel==0, so the back bank is always bank !front_sel.
        case (state)
            INIT: begin
                we0   = 1'b1;
                we1   = 1'b1;
                waddr = clear_addr;
                wdata = CLEAR_COLOR;
                if (clear_addr == LAST_ADDR) begin
                    state_d      = DRAW;
                    clear_addr_d = '0;
                end else begin
                    clear_addr_d = clear_addr + 1'b1;
                end
            end
            DRAW: begin
                if (plot_valid_in) begin
                    if (plot_in_bounds) begin
                        we0 = front_sel;
                        we1 = !front_sel;
                    end else if (drop_count_out != 16'hFFFF) begin
                        drop_count_d = drop_count_out + 16'd1;
                    end
                end
                if (frame_end && swap_pend) begin
                    front_sel_d  = !front_sel;
                    swap_pend_d  = 1'b0;
                    swap_done_d  = 1'b1;
                    state_d      = CLEAR;
                    clear_addr_d = '0;
                end
            end
            CLEAR: begin
                we0   = front_sel;
                we1   = !front_sel;
                waddr = clear_addr;
                wdata = CLEAR_COLOR;
                if (clear_addr == LAST_ADDR) begin
                    state_d      = DRAW;
                    clear_addr_d = '0;
                end else begin
                    clear_addr_d = clear_addr + 1'b1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    fb_bank #(
        .DEPTH (FB_PIXELS),
        .AW    (AW),
        .DW    (16)
    ) u_bank0 (
        .clk_pixel (clk_pixel),
        .we        (we0),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr_s1),
        .rdata     (rdata0)
    );

    fb_bank #(
        .DEPTH (FB_PIXELS),
        .AW    (AW),
        .DW    (16)
    ) u_bank1 (
        .clk_pixel (clk_pixel),
        .we        (we1),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr_s1),
        .rdata     (rdata1)
    );

    always_comb begin
        hs         = hcount_in >> scale_q;
        vs         = vcount_in >> scale_q;
        in_range_c = (hs < 11'(FB_WIDTH)) && (vs < 10'(FB_HEIGHT));
        raddr_c    = in_range_c ? (AW'(vs) * AW'(FB_WIDTH) + AW'(hs)) : '0;
    end

    assign pix_s2    = sel_s2 ? rgb565_t'(rdata1) : rgb565_t'(rdata0);
    assign rgb888_s2 = rgb565_to_rgb888(pix_s2);

    // Stage 1 registers the address; stage 2 is the RAM itself; stage 3 drives the pins.
    always_ff @(posedge clk_pixel or negedge rst_in) begin
        if (!rst_in) begin
            raddr_s1    <= '0;
            in_range_s1 <= 1'b0;
            sel_s1      <= 1'b0;
            in_range_s2 <= 1'b0;
            sel_s2      <= 1'b0;
            red_out     <= 8'd0;
            green_out   <= 8'd0;
            blue_out    <= 8'd0;
        end else begin
            raddr_s1    <= raddr_c;
            in_range_s1 <= in_range_c;
            sel_s1      <= front_sel;
            in_range_s2 <= in_range_s1;
            sel_s2      <= sel_s1;
            red_out     <= in_range_s2 ? rgb888_s2[23:16] : 8'd0;
            green_out   <= in_range_s2 ? rgb888_s2[15:8]  : 8'd0;
            blue_out    <= in_range_s2 ? rgb888_s2[7:0]   : 8'd0;
        end
    end

endmodule

// File: tb/tb_particle_frame_buffer.sv
// Randomized bench for particle_frame_buffer against an image-level model of front/back frames.
module tb_particle_frame_buffer;

    localparam int          W   = 32;
    localparam int          H   = 18;
    localparam int          N   = W * H;
    localparam int          HT  = 1650;
    localparam int          VT  = 750;
    localparam logic [15:0] CLR = 16'h18E3;

    logic        clk_pixel = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [1:0]  scale_log2_in;
    logic        plot_valid_in;
    logic        plot_ready_out;
    logic [15:0] plot_x_in;
    logic [15:0] plot_y_in;
    logic [15:0] plot_color_in;
    logic        swap_req_in;
    logic        swap_done_out;
    logic        busy_out;
    logic [15:0] drop_count_out;
    logic [7:0]  red_out;
    logic [7:0]  green_out;
    logic [7:0]  blue_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] front_img [N];
    logic [15:0] back_img  [N];
    int          mdl_scale;
    int          mdl_drops;
    bit          mdl_pend;
    int          mdl_busy_left;

    particle_frame_buffer #(
        .FB_WIDTH       (W),
        .FB_HEIGHT      (H),
        .H_TOTAL        (HT),
        .V_TOTAL        (VT),
        .CLEAR_COLOR    (CLR),
        .MAX_SCALE_LOG2 (2)
    ) dut (
        .clk_pixel      (clk_pixel),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .scale_log2_in  (scale_log2_in),
        .plot_valid_in  (plot_valid_in),
        .plot_ready_out (plot_ready_out),
        .plot_x_in      (plot_x_in),
        .plot_y_in      (plot_y_in),
        .plot_color_in  (plot_color_in),
        .swap_req_in    (swap_req_in),
        .swap_done_out  (swap_done_out),
        .busy_out       (busy_out),
        .drop_count_out (drop_count_out),
        .red_out        (red_out),
        .green_out      (green_out),
        .blue_out       (blue_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        if (mdl_busy_left > 0) mdl_busy_left--;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            front_img[i] = CLR;
            back_img[i]  = CLR;
        end
        mdl_scale     = 0;
        mdl_drops     = 0;
        mdl_pend      = 1'b0;
        mdl_busy_left = N;
    endtask

    task automatic model_plot(input int x, input int y, input logic [15:0] c);
        if (x < W && y < H) back_img[y * W + x] = c;
        else if (mdl_drops < 65535) mdl_drops++;
    endtask

    function automatic logic [23:0] expect_rgb(input int h, input int v);
        int hs, vs;
        logic [15:0] c;
        hs = h >> mdl_scale;
        vs = v >> mdl_scale;
        if (hs < W && vs < H) begin
            c = front_img[vs * W + hs];
            return {c[15:11], 3'b000, c[10:5], 2'b00, c[4:0], 3'b000};
        end
        return 24'h0;
    endfunction

    task automatic read_px(input int h, input int v);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        repeat (3) tick();
        chk($sformatf("rgb(%0d,%0d)", h, v), {8'h00, red_out, green_out, blue_out},
            {8'h00, expect_rgb(h, v)});
        hcount_in = 11'd0;
        vcount_in = 10'd0;
    endtask

    task automatic plot(input int x, input int y, input logic [15:0] c, output int waited);
        bit rdy;
        waited        = 0;
        plot_valid_in = 1'b1;
        plot_x_in     = 16'(x);
        plot_y_in     = 16'(y);
        plot_color_in = c;
        do begin
            rdy = plot_ready_out;
            tick();
            waited++;
        end while (!rdy && waited < N + 20);
        plot_valid_in = 1'b0;
        if (rdy) model_plot(x, y, c);
        else chk("plot_accept", 32'(rdy), 32'd1);
    endtask

    task automatic pulse_swap();
        swap_req_in = 1'b1;
        tick();
        swap_req_in = 1'b0;
        mdl_pend    = 1'b1;
    endtask

    // One cycle at the frame-end counter position, optionally carrying a plot.
    task automatic frame_end(input bit with_plot, input int x, input int y, input logic [15:0] c);
        bit take;
        bit draw;
        draw      = (mdl_busy_left == 0);
        take      = mdl_pend && draw;
        hcount_in = 11'(HT - 1);
        vcount_in = 10'(VT - 1);
        if (with_plot) begin
            plot_valid_in = 1'b1;
            plot_x_in     = 16'(x);
            plot_y_in     = 16'(y);
            plot_color_in = c;
        end
        tick();
        plot_valid_in = 1'b0;
        hcount_in     = 11'd0;
        vcount_in     = 10'd0;
        if (with_plot && draw) model_plot(x, y, c);
        mdl_scale = (scale_log2_in > 2'd2) ? 2 : int'(scale_log2_in);
        if (take) begin
            front_img     = back_img;
            for (int i = 0; i < N; i++) back_img[i] = CLR;
            mdl_pend      = 1'b0;
            mdl_busy_left = N;
        end
        chk("swap_done", 32'(swap_done_out), 32'(take));
    endtask

    task automatic wait_busy(input string tag);
        int n;
        int exp_n;
        exp_n = mdl_busy_left;
        n     = 0;
        while (busy_out && n < N + 16) begin
            tick();
            n++;
        end
        chk(tag, n, exp_n);
        chk({tag, "_ready"}, 32'(plot_ready_out), 32'd1);
    endtask

    initial begin
        int w;
        int exp_w;
        rst_in        = 1'b0;
        hcount_in     = 11'd0;
        vcount_in     = 10'd0;
        scale_log2_in = 2'd0;
        plot_valid_in = 1'b0;
        plot_x_in     = 16'd0;
        plot_y_in     = 16'd0;
        plot_color_in = 16'd0;
        swap_req_in   = 1'b0;
        model_reset();

        repeat (3) @(posedge clk_pixel);
        #1;
        chk("rst_busy", 32'(busy_out), 32'd1);
        chk("rst_ready", 32'(plot_ready_out), 32'd0);
        chk("rst_done", 32'(swap_done_out), 32'd0);
        chk("rst_drop", 32'(drop_count_out), 32'd0);
        chk("rst_rgb", {8'h00, red_out, green_out, blue_out}, 32'd0);

        rst_in = 1'b1;
        model_reset();
        wait_busy("init_len");
        for (int i = 0; i < 3; i++) read_px($urandom_range(W - 1, 0), $urandom_range(H - 1, 0));

        // Single red pixel, swapped in, neighbours stay at the clear colour.
        plot(5, 7, 16'hF800, w);
        pulse_swap();
        frame_end(1'b0, 0, 0, 16'h0);
        tick();
        chk("swap_done_pulse", 32'(swap_done_out), 32'd0);
        wait_busy("clear_len");
        read_px(5, 7);
        read_px(4, 7);
        read_px(6, 7);
        read_px(5, 6);
        read_px(5, 8);

        // Random plots including out-of-bounds drops and a repeated address.
        plot(W, 0, 16'h1111, w);
        plot(0, H, 16'h2222, w);
        for (int i = 0; i < 40; i++) begin
            plot($urandom_range(W + 3, 0), $urandom_range(H + 2, 0), 16'($urandom), w);
        end
        plot(9, 3, 16'h1234, w);
        plot(9, 3, 16'hABCD, w);
        chk("drops", 32'(drop_count_out), 32'(mdl_drops));
        pulse_swap();
        frame_end(1'b1, 2, 2, 16'h07FF);

        // Request during CLEAR stays pending; a held plot waits out the clear.
        pulse_swap();
        chk("clear_not_ready", 32'(plot_ready_out), 32'd0);
        exp_w = mdl_busy_left + 1;
        plot(3, 3, 16'hF81F, w);
        chk("clear_hold", w, exp_w);
        read_px(9, 3);
        read_px(2, 2);
        read_px(5, 7);
        for (int i = 0; i < 20; i++) read_px($urandom_range(W + 2, 0), $urandom_range(H + 2, 0));

        // Extra requests are absorbed: one swap, then none while clearing or idle.
        pulse_swap();
        tick();
        pulse_swap();
        frame_end(1'b0, 0, 0, 16'h0);
        frame_end(1'b0, 0, 0, 16'h0);
        wait_busy("clear_len2");
        frame_end(1'b0, 0, 0, 16'h0);
        read_px(5, 7);
        read_px(3, 3);

        // 4x upscale.
        plot(1, 1, 16'h07E0, w);
        plot(0, 1, 16'h001F, w);
        scale_log2_in = 2'd2;
        pulse_swap();
        frame_end(1'b0, 0, 0, 16'h0);
        wait_busy("clear_len3");
        read_px(4, 4);
        read_px(7, 7);
        read_px($urandom_range(7, 4), $urandom_range(7, 4));
        read_px(3, 4);
        read_px(W * 4, 0);
        read_px(1280, 4);
        scale_log2_in = 2'd0;
        read_px(4, 4);
        frame_end(1'b0, 0, 0, 16'h0);
        read_px(1, 1);
        read_px(4, 4);
        scale_log2_in = 2'd3;
        frame_end(1'b0, 0, 0, 16'h0);
        read_px(4, 4);
        for (int i = 0; i < 10; i++) read_px($urandom_range(W * 4 + 8, 0), $urandom_range(H * 4 + 8, 0));

        // Reset in the middle of a clear returns to INIT with scale back at 1x.
        scale_log2_in = 2'd2;
        pulse_swap();
        frame_end(1'b0, 0, 0, 16'h0);
        repeat (10) tick();
        #2;
        rst_in = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_out), 32'd1);
        chk("mid_rst_ready", 32'(plot_ready_out), 32'd0);
        chk("mid_rst_drop", 32'(drop_count_out), 32'd0);
        @(posedge clk_pixel);
        #1;
        rst_in = 1'b1;
        model_reset();
        wait_busy("reinit_len");
        read_px(W + 2, 0);
        read_px($urandom_range(W - 1, 0), $urandom_range(H - 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
